matrix_scan: RTL

MATRIX_SCAN -- requirements
Module: matrix_scan

---
 rtl/matrix_scan.sv | 131 +++++++++++++
 1 files changed

// File: rtl/matrix_scan.sv
// Double-buffered 8x8 red/green LED matrix row scanner: one blank cycle between
// rows, DWELL display cycles per row, bank exchange only at frame start.
module matrix_scan #(
  parameter int DWELL = 1
) (
  input  logic       clk1khz,
  input  logic       rst,
  input  logic       off,
  input  logic       wr_en,
  input  logic [2:0] wr_row,
  input  logic [7:0] wr_r,
  input  logic [7:0] wr_g,
  input  logic       swap,
  output logic       swap_pending,
  output logic       swap_ack,
  output logic       frame_start,
  output logic [7:0] row,
  output logic [7:0] r,
  output logic [7:0] g
);

  typedef enum logic {BLANK, SHOW} state_e;

  localparam logic [3:0] DWELL_LAST = 4'(DWELL - 1);

  state_e      state_q, state_d;
  logic [2:0]  scan_row_q, scan_row_d;
  logic [3:0]  dwell_q, dwell_d;
  logic        hold_q, hold_d;
  logic        front_sel_q, front_sel_d;
  logic        pending_q, pending_d;
  logic        boundary;
  logic [15:0] front_row;
  logic [15:0] bank_q [2][8];

  logic       swap_ack_q, frame_start_q;
  logic [7:0] row_q, r_q, g_q;

  // hold_q marks the parked state after reset or blanking; leaving it lands on
  // the row-0 blank cycle so frame_start/exchange happen on the release cycle.
  always_comb begin
    state_d    = state_q;
    scan_row_d = scan_row_q;
    dwell_d    = dwell_q;
    hold_d     = hold_q;
    if (off) begin
      state_d    = BLANK;
      scan_row_d = 3'd0;
      dwell_d    = 4'd0;
      hold_d     = 1'b1;
    end else if (hold_q) begin
      state_d    = BLANK;
      scan_row_d = 3'd0;
      dwell_d    = 4'd0;
      hold_d     = 1'b0;
    end else if (state_q == BLANK) begin
      state_d = SHOW;
      dwell_d = 4'd0;
    end else if (dwell_q == DWELL_LAST) begin
      state_d    = BLANK;
      scan_row_d = scan_row_q + 3'd1;
      dwell_d    = 4'd0;
    end else begin
      dwell_d = dwell_q + 4'd1;
    end

    boundary    = !off && (state_d == BLANK) && (scan_row_d == 3'd0);
    front_sel_d = front_sel_q;
    pending_d   = pending_q | swap;
    if (boundary && pending_q) begin
      front_sel_d = ~front_sel_q;
      pending_d   = 1'b0;
    end

    // Front bank is never written and only changes on a blank cycle, so the
    // pre-edge contents are exactly what the upcoming SHOW cycle must display.
    front_row = bank_q[front_sel_q][scan_row_d];
  end

  always_ff @(posedge clk1khz) begin
    if (rst) begin
      state_q       <= BLANK;
      scan_row_q    <= 3'd0;
      dwell_q       <= 4'd0;
      hold_q        <= 1'b1;
      front_sel_q   <= 1'b0;
      pending_q     <= 1'b0;
      swap_ack_q    <= 1'b0;
      frame_start_q <= 1'b0;
      row_q         <= 8'hFF;
      r_q           <= 8'h00;
      g_q           <= 8'h00;
      // NOTE: the frame store is cleared on reset on purpose -- it is only
      // 2x8x16 flops and a reset must never display stale picture data.
      for (int b = 0; b < 2; b++) begin
        for (int i = 0; i < 8; i++) begin
          bank_q[b][i] <= 16'h0000;
        end
      end
    end else begin
      state_q     <= state_d;
      scan_row_q  <= scan_row_d;
      dwell_q     <= dwell_d;
      hold_q      <= hold_d;
      front_sel_q <= front_sel_d;
      pending_q   <= pending_d;
      if (wr_en) begin
        bank_q[~front_sel_q][wr_row] <= {wr_r, wr_g};
      end
      swap_ack_q    <= boundary && pending_q;
      frame_start_q <= boundary;
      if (state_d == SHOW) begin
        row_q <= ~(8'h01 << scan_row_d);
        r_q   <= front_row[15:8];
        g_q   <= front_row[7:0];
      end else begin
        row_q <= 8'hFF;
        r_q   <= 8'h00;
        g_q   <= 8'h00;
      end
    end
  end

  assign swap_pending = pending_q;
  assign swap_ack     = swap_ack_q;
  assign frame_start  = frame_start_q;
  assign row          = row_q;
  assign r            = r_q;
  assign g            = g_q;

endmodule
